alu_issue_queue: RTL and testbench

Command front-end for the 8-bit ALU stage: it buffers operand/opcode commands from a valid/ready producer and issues at most one per cycle to the ALU's operand inputs. It tracks each command through the ALU's one-cycle registered latency and returns results, in order and tagged, through a credit-protected response FIFO. It also screens illegal opcodes and divide-by-zero so the ALU is only ever driven with defined operations.

---
 rtl/alu_issue_queue.sv | 227 ++++++++++++++++++++++
 tb/tb_alu_issue_queue.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_queue.sv
// alu_issue_queue
// Command front-end for the 8-bit ALU stage. Commands from a valid/ready
// producer are buffered in a small FIFO. At most one per cycle is issued into
// a registered drive stage (S1) that feeds the ALU operand inputs. Each command
// is tracked through the ALU's one-cycle registered latency (S2). Results go
// back in order, tagged, through a response FIFO whose space is reserved
// before issue. Illegal opcodes and divide-by-zero are screened at issue time.
// For those, the ALU only ever sees the idle operation (AND of zeros).
//
// Ports
//   clk_i, rst_i         clock, synchronous active-high reset
//   cmd_valid_i/ready_o  command handshake (ready = not full and not in reset)
//   cmd_a_i, cmd_b_i     8-bit operands
//   cmd_op_i             0 add, 1 sub, 2 mul, 3 div, 4 and, 5 xor
//   cmd_cin_i            carry-in, used by add only
//   cmd_tag_i            caller tag echoed on the response
//   alu_*_o              registered ALU operand/opcode/carry drive
//   alu_result_i, alu_c_out_i, alu_z_flag_i   ALU registered outputs
//   rsp_valid_o/ready_i  response handshake
//   rsp_*_o              head-of-queue response fields (zero when empty)
//   cmd_count_o          command FIFO occupancy
module alu_issue_queue #(
  parameter int CMD_DEPTH = 4,
  parameter int RSP_DEPTH = 4,
  parameter int TAG_W     = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       cmd_valid_i,
  output logic                       cmd_ready_o,
  input  logic [7:0]                 cmd_a_i,
  input  logic [7:0]                 cmd_b_i,
  input  logic [3:0]                 cmd_op_i,
  input  logic                       cmd_cin_i,
  input  logic [TAG_W-1:0]           cmd_tag_i,
  output logic [7:0]                 alu_a_o,
  output logic [7:0]                 alu_b_o,
  output logic [3:0]                 alu_op_code_o,
  output logic                       alu_c_in_o,
  input  logic [15:0]                alu_result_i,
  input  logic                       alu_c_out_i,
  input  logic                       alu_z_flag_i,
  output logic                       rsp_valid_o,
  input  logic                       rsp_ready_i,
  output logic [15:0]                rsp_result_o,
  output logic                       rsp_c_out_o,
  output logic                       rsp_z_flag_o,
  output logic                       rsp_err_o,
  output logic [TAG_W-1:0]           rsp_tag_o,
  output logic [$clog2(CMD_DEPTH):0] cmd_count_o
);

  localparam int CPW  = $clog2(CMD_DEPTH);
  localparam int RPW  = $clog2(RSP_DEPTH);
  localparam int CE_W = 21 + TAG_W;  // {tag, cin, op, b, a}
  localparam int RE_W = 19 + TAG_W;  // {err, z, c_out, tag, result}
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_DIV  = 4'd3;
  localparam logic [3:0] OP_IDLE = 4'd4;
  localparam logic [3:0] OP_MAX  = 4'd5;

  logic [CE_W-1:0]  cmd_mem_q [CMD_DEPTH];
  logic [CPW-1:0]   cmd_wr_q, cmd_wr_d, cmd_rd_q, cmd_rd_d;
  logic [CPW:0]     cmd_cnt_q, cmd_cnt_d;
  logic [RE_W-1:0]  rsp_mem_q [RSP_DEPTH];
  logic [RPW-1:0]   rsp_wr_q, rsp_wr_d, rsp_rd_q, rsp_rd_d;
  logic [RPW:0]     rsp_cnt_q, rsp_cnt_d;

  logic             s1_valid_q, s1_valid_d, s1_err_q, s1_err_d, s1_add_q, s1_add_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
  logic [7:0]       alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [3:0]       alu_op_q, alu_op_d;
  logic             alu_cin_q, alu_cin_d;
  logic             s2_valid_q, s2_err_q, s2_add_q;
  logic [TAG_W-1:0] s2_tag_q;

  logic             cmd_push, cmd_issue, rsp_pop, head_err;
  logic [CE_W-1:0]  head;
  logic [RE_W-1:0]  rsp_entry, rsp_head;
  logic [RPW+1:0]   committed;

  assign cmd_ready_o = !rst_i && (cmd_cnt_q != (CPW+1)'(CMD_DEPTH));
  assign cmd_push    = cmd_valid_i && cmd_ready_o;
  assign rsp_valid_o = (rsp_cnt_q != '0);
  assign rsp_pop     = rsp_valid_o && rsp_ready_i;
  assign head        = cmd_mem_q[cmd_rd_q];
  assign head_err    = (head[19:16] > OP_MAX) || ((head[19:16] == OP_DIV) && (head[15:8] == 8'd0));

  // Every command in S1/S2 owns a response slot, so a write can never find the FIFO full.
  assign committed = {1'b0, rsp_cnt_q} + (RPW+2)'(s1_valid_q) + (RPW+2)'(s2_valid_q);
  assign cmd_issue = (cmd_cnt_q != '0) && (committed < (RPW+2)'(RSP_DEPTH));

  // Flagged commands report all-ones with z cleared; carry-out means something only for add.
  assign rsp_entry = {s2_err_q,
                      s2_err_q ? 1'b0 : alu_z_flag_i,
                      s2_add_q & alu_c_out_i,
                      s2_tag_q,
                      s2_err_q ? 16'hFFFF : alu_result_i};
  assign rsp_head  = rsp_mem_q[rsp_rd_q];

  // Next-state for FIFO pointers/counts and the S1 issue register.
  always_comb begin
    cmd_wr_d   = cmd_wr_q;
    cmd_rd_d   = cmd_rd_q;
    rsp_wr_d   = rsp_wr_q;
    rsp_rd_d   = rsp_rd_q;
    cmd_cnt_d  = cmd_cnt_q + (CPW+1)'(cmd_push) - (CPW+1)'(cmd_issue);
    rsp_cnt_d  = rsp_cnt_q + (RPW+1)'(s2_valid_q) - (RPW+1)'(rsp_pop);
    s1_valid_d = cmd_issue;
    s1_tag_d   = '0;
    s1_err_d   = 1'b0;
    s1_add_d   = 1'b0;
    alu_a_d    = 8'd0;
    alu_b_d    = 8'd0;
    alu_op_d   = OP_IDLE;
    alu_cin_d  = 1'b0;
    if (cmd_push) begin
      cmd_wr_d = cmd_wr_q + CPW'(1);
    end else begin
      cmd_wr_d = cmd_wr_q;
    end
    if (s2_valid_q) begin
      rsp_wr_d = rsp_wr_q + RPW'(1);
    end else begin
      rsp_wr_d = rsp_wr_q;
    end
    if (rsp_pop) begin
      rsp_rd_d = rsp_rd_q + RPW'(1);
    end else begin
      rsp_rd_d = rsp_rd_q;
    end
    if (cmd_issue) begin
      cmd_rd_d = cmd_rd_q + CPW'(1);
      s1_tag_d = head[CE_W-1:21];
      s1_err_d = head_err;
      s1_add_d = (head[19:16] == OP_ADD);
      // A screened command keeps its slot in the pipeline but drives the idle op.
      if (!head_err) begin
        alu_a_d   = head[7:0];
        alu_b_d   = head[15:8];
        alu_op_d  = head[19:16];
        alu_cin_d = head[20] && (head[19:16] == OP_ADD);
      end else begin
        alu_op_d  = OP_IDLE;
      end
    end else begin
      cmd_rd_d = cmd_rd_q;
    end
  end

  // Control state, issue register and ALU-stage tracking, with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cmd_wr_q   <= '0;
      cmd_rd_q   <= '0;
      cmd_cnt_q  <= '0;
      rsp_wr_q   <= '0;
      rsp_rd_q   <= '0;
      rsp_cnt_q  <= '0;
      s1_valid_q <= 1'b0;
      s1_tag_q   <= '0;
      s1_err_q   <= 1'b0;
      s1_add_q   <= 1'b0;
      alu_a_q    <= 8'd0;
      alu_b_q    <= 8'd0;
      alu_op_q   <= OP_IDLE;
      alu_cin_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_tag_q   <= '0;
      s2_err_q   <= 1'b0;
      s2_add_q   <= 1'b0;
    end else begin
      cmd_wr_q   <= cmd_wr_d;
      cmd_rd_q   <= cmd_rd_d;
      cmd_cnt_q  <= cmd_cnt_d;
      rsp_wr_q   <= rsp_wr_d;
      rsp_rd_q   <= rsp_rd_d;
      rsp_cnt_q  <= rsp_cnt_d;
      s1_valid_q <= s1_valid_d;
      s1_tag_q   <= s1_tag_d;
      s1_err_q   <= s1_err_d;
      s1_add_q   <= s1_add_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_op_q   <= alu_op_d;
      alu_cin_q  <= alu_cin_d;
      s2_valid_q <= s1_valid_q;
      s2_tag_q   <= s1_tag_q;
      s2_err_q   <= s1_err_q;
      s2_add_q   <= s1_add_q;
    end
  end

  // FIFO storage; contents are only observed through valid pointers, so no reset.
  always_ff @(posedge clk_i) begin
    if (cmd_push) begin
      cmd_mem_q[cmd_wr_q] <= {cmd_tag_i, cmd_cin_i, cmd_op_i, cmd_b_i, cmd_a_i};
    end
    if (s2_valid_q) begin
      rsp_mem_q[rsp_wr_q] <= rsp_entry;
    end
  end

  // Head response fields; zero when empty so stale entries never show after reset.
  always_comb begin
    if (rsp_valid_o) begin
      rsp_result_o = rsp_head[15:0];
      rsp_tag_o    = rsp_head[TAG_W+15:16];
      rsp_c_out_o  = rsp_head[TAG_W+16];
      rsp_z_flag_o = rsp_head[TAG_W+17];
      rsp_err_o    = rsp_head[TAG_W+18];
    end else begin
      rsp_result_o = 16'd0;
      rsp_tag_o    = '0;
      rsp_c_out_o  = 1'b0;
      rsp_z_flag_o = 1'b0;
      rsp_err_o    = 1'b0;
    end
  end

  assign alu_a_o       = alu_a_q;
  assign alu_b_o       = alu_b_q;
  assign alu_op_code_o = alu_op_q;
  assign alu_c_in_o    = alu_cin_q;
  assign cmd_count_o   = cmd_cnt_q;

endmodule

// File: tb/tb_alu_issue_queue.sv
module tb_alu_issue_queue;
  localparam int CMD_DEPTH = 4;
  localparam int RSP_DEPTH = 4;
  localparam int TAG_W     = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid, cmd_ready, cmd_cin;
  logic [7:0]       cmd_a, cmd_b;
  logic [3:0]       cmd_op;
  logic [TAG_W-1:0] cmd_tag;
  logic [7:0]       alu_a, alu_b;
  logic [3:0]       alu_op;
  logic             alu_cin;
  logic [15:0]      alu_result = 16'd0;
  logic             alu_c_out = 1'b0, alu_z = 1'b0;
  logic             rsp_valid, rsp_ready, rsp_c_out, rsp_z_flag, rsp_err;
  logic [15:0]      rsp_result;
  logic [TAG_W-1:0] rsp_tag;
  logic [$clog2(CMD_DEPTH):0] cmd_count;

  int n_checks = 0;
  int n_errors = 0;
  int pop_cnt  = 0;
  logic [22:0] exp_q [$];

  alu_issue_queue #(.CMD_DEPTH(CMD_DEPTH), .RSP_DEPTH(RSP_DEPTH), .TAG_W(TAG_W)) dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_a_i(cmd_a), .cmd_b_i(cmd_b), .cmd_op_i(cmd_op), .cmd_cin_i(cmd_cin), .cmd_tag_i(cmd_tag),
    .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_op_code_o(alu_op), .alu_c_in_o(alu_cin),
    .alu_result_i(alu_result), .alu_c_out_i(alu_c_out), .alu_z_flag_i(alu_z),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_result_o(rsp_result), .rsp_c_out_o(rsp_c_out), .rsp_z_flag_o(rsp_z_flag),
    .rsp_err_o(rsp_err), .rsp_tag_o(rsp_tag), .cmd_count_o(cmd_count)
  );

  always #5 clk = ~clk;

  // ALU arithmetic: add includes carry-in, sub wraps mod 2^16, sub/div unsigned.
  function automatic logic [15:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                         input logic [3:0] op, input logic cin);
    case (op)
      4'd0:    return 16'(a) + 16'(b) + 16'(cin);
      4'd1:    return 16'(a) - 16'(b);
      4'd2:    return 16'(a) * 16'(b);
      4'd3:    return (b == 8'd0) ? 16'h1234 : 16'(a) / 16'(b);
      4'd4:    return 16'(a & b);
      4'd5:    return 16'(a ^ b);
      default: return 16'h0;
    endcase
  endfunction

  // Expected response {err, c_out, z, tag, result} for one accepted command.
  function automatic logic [22:0] ref_rsp(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                                          input logic cin, input logic [TAG_W-1:0] tag);
    logic err;
    logic [15:0] r;
    err = (op > 4'd5) || (op == 4'd3 && b == 8'd0);
    r   = alu_fn(a, b, op, cin);
    if (err) return {1'b1, 1'b0, 1'b0, tag, 16'hFFFF};
    return {1'b0, (op == 4'd0) ? r[8] : 1'b0, (r == 16'd0), tag, r};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural ALU: one-cycle registered; c_out is bit 8 for every op.
  always @(posedge clk) begin
    alu_result <= alu_fn(alu_a, alu_b, alu_op, alu_cin);
    alu_c_out  <= alu_fn(alu_a, alu_b, alu_op, alu_cin) >> 8;
    alu_z      <= (alu_fn(alu_a, alu_b, alu_op, alu_cin) == 16'd0);
  end

  // Scoreboard: record accepted commands, compare each popped response in order.
  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (cmd_valid && cmd_ready) exp_q.push_back(ref_rsp(cmd_a, cmd_b, cmd_op, cmd_cin, cmd_tag));
      if (rsp_valid && rsp_ready) begin
        pop_cnt++;
        check_eq("rsp_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0)
          check_eq("rsp", 32'({rsp_err, rsp_c_out, rsp_z_flag, rsp_tag, rsp_result}), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                       input logic cin, input logic [TAG_W-1:0] tag);
    cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_op = op; cmd_cin = cin; cmd_tag = tag;
  endtask

  task automatic drive_rand(input int tag);
    drive(8'($urandom), ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom),
          4'($urandom_range(0, 7)), 1'($urandom), TAG_W'(tag));
  endtask

  // Push n commands (whatever rsp_ready is), bounded by a cycle budget.
  task automatic push_n(input int n, input int budget, output int accepted);
    logic took;
    accepted = 0;
    for (int c = 0; c < budget && accepted < n; c++) begin
      drive_rand(accepted);
      took = cmd_ready;
      step();
      if (took) accepted++;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int c = 0; c < 60 && exp_q.size() != 0; c++) step();
    step();
    check_eq(tag, 32'(exp_q.size()), 32'd0);
    check_eq({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int acc, base, seen;
    logic [15:0] s_res [4] = '{16'hFFFE, 16'd65025, 16'd0, 16'd0};
    logic        s_z   [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0]  s_a   [4] = '{8'd5, 8'd255, 8'hF0, 8'hAA};
    logic [7:0]  s_b   [4] = '{8'd7, 8'd255, 8'h0F, 8'hAA};
    logic [3:0]  s_op  [4] = '{4'd1, 4'd2, 4'd4, 4'd5};

    rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_a = 8'd0; cmd_b = 8'd0; cmd_op = 4'd0; cmd_cin = 1'b0; cmd_tag = '0;
    step(); step();
    check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_cmd_count", 32'(cmd_count), 32'd0);
    check_eq("rst_rsp_fields", 32'({rsp_err, rsp_c_out, rsp_z_flag, rsp_tag, rsp_result}), 32'd0);
    check_eq("rst_alu_idle", 32'({alu_op, alu_a, alu_b, alu_cin}), 32'({4'd4, 17'd0}));
    rst = 1'b0;
    #1;
    check_eq("rst_release_ready", 32'(cmd_ready), 32'd1);

    // Single add, latency check.
    rsp_ready = 1'b1;
    drive(8'd200, 8'd100, 4'd0, 1'b1, 4'd3);
    step();
    cmd_valid = 1'b0;
    step();
    check_eq("add_s1_drive", 32'({alu_op, alu_a, alu_b, alu_cin}), 32'({4'd0, 8'd200, 8'd100, 1'b1}));
    step();
    check_eq("add_rsp_early", 32'(rsp_valid), 32'd0);
    step();
    check_eq("add_rsp_valid", 32'(rsp_valid), 32'd1);
    check_eq("add_rsp", 32'({rsp_err, rsp_c_out, rsp_z_flag, rsp_tag, rsp_result}),
             32'({1'b0, 1'b1, 1'b0, 4'd3, 16'd301}));
    step();

    // Back-to-back stream, one response per cycle.
    for (int i = 0; i < 4; i++) begin
      drive(s_a[i], s_b[i], s_op[i], 1'b0, TAG_W'(i + 4));
      step();
    end
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_eq("stream_valid", 32'(rsp_valid), 32'd1);
      check_eq("stream_rsp", 32'({rsp_c_out, rsp_z_flag, rsp_tag, rsp_result}),
               32'({1'b0, s_z[i], 4'(i + 4), s_res[i]}));
      step();
    end

    // Illegal opcode and divide-by-zero: idle drive while in S1.
    drive(8'd1, 8'd2, 4'd9, 1'b0, 4'd1);
    step();
    drive(8'd10, 8'd0, 4'd3, 1'b0, 4'd2);
    step();
    cmd_valid = 1'b0;
    check_eq("illegal_s1_idle", 32'({alu_op, alu_a, alu_b}), 32'({4'd4, 16'd0}));
    step();
    check_eq("div0_s1_idle", 32'({alu_op, alu_a, alu_b}), 32'({4'd4, 16'd0}));
    step();
    check_eq("illegal_rsp", 32'({rsp_valid, rsp_err, rsp_z_flag, rsp_tag, rsp_result}),
             32'({1'b1, 1'b1, 1'b0, 4'd1, 16'hFFFF}));
    step();
    check_eq("div0_rsp", 32'({rsp_valid, rsp_err, rsp_z_flag, rsp_tag, rsp_result}),
             32'({1'b1, 1'b1, 1'b0, 4'd2, 16'hFFFF}));
    drain("directed_drain");

    // Backpressure: only RSP_DEPTH issue, then the command FIFO fills.
    rsp_ready = 1'b0;
    push_n(10, 14, acc);
    check_eq("bp_accepted", 32'(acc), 32'(RSP_DEPTH + CMD_DEPTH));
    check_eq("bp_cmd_count", 32'(cmd_count), 32'(CMD_DEPTH));
    check_eq("bp_cmd_ready", 32'(cmd_ready), 32'd0);
    check_eq("bp_rsp_tag_stable", 32'({rsp_valid, rsp_tag}), 32'({1'b1, 4'd0}));
    base = pop_cnt;
    rsp_ready = 1'b1;
    push_n(2, 20, acc);
    check_eq("bp_remaining", 32'(acc), 32'd2);
    drain("bp_drain");
    check_eq("bp_pops", 32'(pop_cnt - base), 32'd10);

    // Steady push/pop with two commands held in the FIFO.
    rsp_ready = 1'b0;
    push_n(6, 12, acc);
    step(); step(); step();
    check_eq("pp_setup_count", 32'(cmd_count), 32'd2);
    rsp_ready = 1'b1;
    step();
    for (int i = 0; i < 20; i++) begin
      drive_rand(i);
      step();
      check_eq("pp_count", 32'(cmd_count), 32'd2);
    end
    drain("pp_drain");

    // Reset with commands queued and in flight: everything is discarded.
    rsp_ready = 1'b0;
    push_n(5, 8, acc);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check_eq("mrst_cmd_ready", 32'(cmd_ready), 32'd1);
    check_eq("mrst_cmd_count", 32'(cmd_count), 32'd0);
    check_eq("mrst_rsp", 32'({rsp_valid, rsp_tag, rsp_result}), 32'd0);
    rsp_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (rsp_valid) seen++;
    end
    check_eq("mrst_no_rsp", 32'(seen), 32'd0);

    // Randomised traffic with random consumer backpressure.
    for (int i = 0; i < 400; i++) begin
      drive_rand(i);
      cmd_valid = ($urandom_range(0, 3) != 0);
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    drain("rand_drain");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
